// File: rtl/pong_game_ctrl.sv
// Match sequencer for the VGA pong datapath. Runs the match states, gates ball
// motion and paddle input, and keeps both players' scores.
module pong_game_ctrl #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned SCORE_FRAMES = 90,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned MID_LINE     = 275
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start_key,
    input  logic        fell,
    input  logic [15:0] ball_top,
    output logic        ball_run,
    output logic        ball_recentre,
    output logic        paddle_en,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic [1:0]  winner,
    output logic [2:0]  state_o
);

    // Interface semantics: frame_tick and ball_recentre are single-cycle pulses;
    // fell, ball_run and paddle_en are levels; only rising edges of start_key/fell act.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  SCORE_LAST = 8'(SCORE_FRAMES - 1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [15:0] MID        = 16'(MID_LINE);

    state_t     state;
    logic [7:0] frame_cnt;

    logic start_sync1;
    logic start_sync2;
    logic start_dly;
    logic start_rise;
    logic fell_q;
    logic fell_rise;

    // start_key comes from a pad: two flops for metastability, one more for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync1 <= 1'b0;
            start_sync2 <= 1'b0;
            start_dly   <= 1'b0;
            fell_q      <= 1'b0;
        end else begin
            start_sync1 <= start_key;
            start_sync2 <= start_sync1;
            start_dly   <= start_sync2;
            fell_q      <= fell;
        end
    end

    assign start_rise = start_sync2 & ~start_dly;
    assign fell_rise  = fell & ~fell_q;
    assign state_o    = state;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            frame_cnt     <= 8'd0;
            ball_run      <= 1'b0;
            ball_recentre <= 1'b0;
            paddle_en     <= 1'b0;
            score1        <= 4'd0;
            score2        <= 4'd0;
            winner        <= 2'b00;
        end else begin
            ball_recentre <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ball_run  <= 1'b0;
                    paddle_en <= 1'b0;
                    if (start_rise) begin
                        state         <= ST_SERVE;
                        ball_recentre <= 1'b1;
                        paddle_en     <= 1'b1;
                        frame_cnt     <= 8'd0;
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            state     <= ST_PLAY;
                            ball_run  <= 1'b1;
                            frame_cnt <= 8'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                // A miss takes priority over any frame_tick landing on the same cycle.
                ST_PLAY: begin
                    if (fell_rise) begin
                        state     <= ST_POINT;
                        ball_run  <= 1'b0;
                        paddle_en <= 1'b0;
                        frame_cnt <= 8'd0;
                        if (ball_top < MID) begin
                            score2 <= sat_inc(score2);
                        end else begin
                            score1 <= sat_inc(score1);
                        end
                    end
                end

                ST_POINT: begin
                    if (frame_tick) begin
                        if (frame_cnt == SCORE_LAST) begin
                            frame_cnt <= 8'd0;
                            if (score1 >= WIN) begin
                                state  <= ST_OVER;
                                winner <= 2'b01;
                            end else if (score2 >= WIN) begin
                                state  <= ST_OVER;
                                winner <= 2'b10;
                            end else begin
                                state         <= ST_SERVE;
                                ball_recentre <= 1'b1;
                                paddle_en     <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                ST_OVER: begin
                    ball_run  <= 1'b0;
                    paddle_en <= 1'b0;
                    if (start_rise) begin
                        state         <= ST_SERVE;
                        score1        <= 4'd0;
                        score2        <= 4'd0;
                        winner        <= 2'b00;
                        ball_recentre <= 1'b1;
                        paddle_en     <= 1'b1;
                        frame_cnt     <= 8'd0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    ball_run  <= 1'b0;
                    paddle_en <= 1'b0;
                    frame_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: full match flow, simultaneous miss/tick,
// and asynchronous reset in the middle of a point pause.
module tb_pong_game_ctrl;

    localparam int TICK_PERIOD = 20;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        start_key;
    logic        fell;
    logic [15:0] ball_top;
    logic        ball_run;
    logic        ball_recentre;
    logic        paddle_en;
    logic [3:0]  score1;
    logic [3:0]  score2;
    logic [1:0]  winner;
    logic [2:0]  state_o;

    pong_game_ctrl #(
        .SERVE_FRAMES(4),
        .SCORE_FRAMES(8),
        .WIN_SCORE   (3),
        .MID_LINE    (275)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start_key    (start_key),
        .fell         (fell),
        .ball_top     (ball_top),
        .ball_run     (ball_run),
        .ball_recentre(ball_recentre),
        .paddle_en    (paddle_en),
        .score1       (score1),
        .score2       (score2),
        .winner       (winner),
        .state_o      (state_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [15:0] exp_q[$];
    int checks      = 0;
    int failures    = 0;
    int tick_div    = 0;
    int ticks_sent  = 0;
    int pulses_seen = 0;
    int tick_base   = 0;
    int pulse_base  = 0;

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        exp_q.push_back(exp);
        check(tag, obs);
    endtask

    // Driver tasks: always entered and left at a falling edge.
    task automatic step();
        frame_tick = (tick_div == TICK_PERIOD - 1);
        if (frame_tick) ticks_sent++;
        tick_div = (tick_div == TICK_PERIOD - 1) ? 0 : tick_div + 1;
        @(negedge clk);
        frame_tick = 1'b0;
        if (ball_recentre) pulses_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (state_o !== target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 16'(state_o), 16'(target));
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        start_key  = 1'b0;
        fell       = 1'b0;
        ball_top   = 16'd300;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_state", 16'(state_o), 16'(S_IDLE));
        chk("rst_ball_run", 16'(ball_run), 16'd0);
        chk("rst_recentre", 16'(ball_recentre), 16'd0);
        chk("rst_paddle_en", 16'(paddle_en), 16'd0);
        chk("rst_score1", 16'(score1), 16'd0);
        chk("rst_score2", 16'(score2), 16'd0);
        chk("rst_winner", 16'(winner), 16'd0);

        run(10);
        chk("idle_hold", 16'(state_o), 16'(S_IDLE));

        // Start press: edge reaches the FSM on the third clock.
        start_key  = 1'b1;
        pulse_base = pulses_seen;
        run(2);
        chk("start_not_yet", 16'(state_o), 16'(S_IDLE));
        step();
        tick_base = ticks_sent;
        chk("start_state", 16'(state_o), 16'(S_SERVE));
        chk("start_recentre", 16'(ball_recentre), 16'd1);
        chk("serve_paddle_en", 16'(paddle_en), 16'd1);
        chk("serve_ball_run", 16'(ball_run), 16'd0);
        step();
        chk("recentre_one_clk", 16'(ball_recentre), 16'd0);
        step();
        start_key = 1'b0;
        chk("start_pulses", 16'(pulses_seen - pulse_base), 16'd1);

        wait_state(S_PLAY, 400, "reach_play1");
        chk("serve_ticks1", 16'(ticks_sent - tick_base), 16'd4);
        chk("play_ball_run", 16'(ball_run), 16'd1);
        chk("play_paddle_en", 16'(paddle_en), 16'd1);

        // Top-half miss held for 50 clocks scores once for player 2.
        ball_top = 16'd60;
        fell     = 1'b1;
        step();
        tick_base  = ticks_sent;
        pulse_base = pulses_seen;
        chk("miss1_state", 16'(state_o), 16'(S_POINT));
        chk("miss1_ball_run", 16'(ball_run), 16'd0);
        chk("miss1_paddle_en", 16'(paddle_en), 16'd0);
        chk("miss1_score2", 16'(score2), 16'd1);
        chk("miss1_score1", 16'(score1), 16'd0);
        run(49);
        chk("miss1_hold_score2", 16'(score2), 16'd1);
        chk("miss1_hold_score1", 16'(score1), 16'd0);
        fell = 1'b0;
        wait_state(S_SERVE, 400, "reach_serve2");
        chk("point_ticks1", 16'(ticks_sent - tick_base), 16'd8);
        chk("point_recentre1", 16'(pulses_seen - pulse_base), 16'd1);
        tick_base = ticks_sent;
        wait_state(S_PLAY, 400, "reach_play2");
        chk("serve_ticks2", 16'(ticks_sent - tick_base), 16'd4);

        // Three bottom-half misses: player 1 reaches the winning score.
        for (int i = 1; i <= 3; i++) begin
            ball_top = 16'd490;
            fell     = 1'b1;
            step();
            tick_base = ticks_sent;
            chk("miss_score1", 16'(score1), 16'(i));
            chk("miss_state", 16'(state_o), 16'(S_POINT));
            fell = 1'b0;
            step();
            if (i < 3) begin
                wait_state(S_SERVE, 400, "loop_serve");
                wait_state(S_PLAY, 400, "loop_play");
            end else begin
                wait_state(S_OVER, 400, "reach_over");
                chk("over_point_ticks", 16'(ticks_sent - tick_base), 16'd8);
                chk("over_winner", 16'(winner), 16'b01);
                chk("over_ball_run", 16'(ball_run), 16'd0);
                chk("over_paddle_en", 16'(paddle_en), 16'd0);
            end
        end

        repeat (3) begin
            fell = 1'b1;
            step();
            fell = 1'b0;
            step();
        end
        chk("over_hold_score1", 16'(score1), 16'd3);
        chk("over_hold_score2", 16'(score2), 16'd1);
        chk("over_hold_state", 16'(state_o), 16'(S_OVER));

        // Restart from OVER.
        start_key  = 1'b1;
        pulse_base = pulses_seen;
        run(2);
        chk("restart_not_yet", 16'(state_o), 16'(S_OVER));
        step();
        chk("restart_state", 16'(state_o), 16'(S_SERVE));
        chk("restart_score1", 16'(score1), 16'd0);
        chk("restart_score2", 16'(score2), 16'd0);
        chk("restart_winner", 16'(winner), 16'd0);
        run(2);
        start_key = 1'b0;
        chk("restart_pulses", 16'(pulses_seen - pulse_base), 16'd1);

        // Miss and frame_tick on the same clock: miss wins, tick is not counted.
        wait_state(S_PLAY, 400, "reach_play3");
        while (tick_div != TICK_PERIOD - 1) step();
        ball_top = 16'd60;
        fell     = 1'b1;
        step();
        chk("coinc_state", 16'(state_o), 16'(S_POINT));
        chk("coinc_score2", 16'(score2), 16'd1);
        chk("coinc_score1", 16'(score1), 16'd0);
        tick_base = ticks_sent;
        fell      = 1'b0;
        wait_state(S_SERVE, 400, "coinc_serve");
        chk("coinc_point_ticks", 16'(ticks_sent - tick_base), 16'd8);

        // Asynchronous reset in the middle of a point pause.
        wait_state(S_PLAY, 400, "reach_play4");
        ball_top = 16'd490;
        fell     = 1'b1;
        step();
        fell = 1'b0;
        run(30);
        chk("pre_reset_state", 16'(state_o), 16'(S_POINT));
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 16'(state_o), 16'(S_IDLE));
        chk("async_score1", 16'(score1), 16'd0);
        chk("async_score2", 16'(score2), 16'd0);
        chk("async_winner", 16'(winner), 16'd0);
        chk("async_ball_run", 16'(ball_run), 16'd0);
        chk("async_paddle_en", 16'(paddle_en), 16'd0);
        chk("async_recentre", 16'(ball_recentre), 16'd0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        pulse_base = pulses_seen;
        run(100);
        chk("post_reset_idle", 16'(state_o), 16'(S_IDLE));
        chk("post_reset_pulses", 16'(pulses_seen - pulse_base), 16'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
